// File: rtl/bbox_extractor.sv
// bbox_extractor: recovers the axis-aligned bounding rectangle of all masked
// pixels in a raster-order frame and publishes it on a valid/ready handshake.
// Coordinates are half-open: [x_out_1, x_out_2) x [y_out_1, y_out_2).
// Pipeline: stage 1 registers the pixel inputs, stage 2 accumulates, stage 3
// loads the published result, so a frame's last pixel sampled on edge N shows
// up on the outputs after edge N+2.
// Optional build macro: BBOX_MASK_DEBOUNCE_EN -- a masked pixel only counts if
// the previous valid pixel on the same row (hcount-1) was also masked.
module bbox_extractor #(
  parameter int H_ACTIVE   = 1280,
  parameter int V_ACTIVE   = 720,
  parameter int MIN_PIXELS = 16
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  input  logic        valid_in,
  input  logic        mask_in,
  input  logic        rect_ready_in,
  output logic        rect_valid_out,
  output logic        found_out,
  output logic [10:0] x_out_1,
  output logic [9:0]  y_out_1,
  output logic [10:0] x_out_2,
  output logic [9:0]  y_out_2,
  output logic [20:0] pixel_count_out,
  output logic        overrun_out
);

  localparam logic [10:0] H_ACT_C   = 11'(H_ACTIVE);
  localparam logic [9:0]  V_ACT_C   = 10'(V_ACTIVE);
  localparam logic [10:0] H_LAST_C  = 11'(H_ACTIVE - 1);
  localparam logic [9:0]  V_LAST_C  = 10'(V_ACTIVE - 1);
  localparam logic [20:0] MIN_C     = 21'(MIN_PIXELS);
  localparam logic [20:0] CNT_MAX_C = 21'h1F_FFFF;

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_ACCUM = 1'b1} state_t;

  // stage 1 registers
  logic [10:0] h1_r;
  logic [9:0]  v1_r;
  logic        valid1_r;
  logic        mask1_r;

  // stage 2 accumulators
  state_t      state_r;
  logic [10:0] min_x_r, max_x_r;
  logic [9:0]  min_y_r, max_y_r;
  logic [20:0] cnt_r;
  logic        done_r;

  // combinational next-state for the accumulators
  logic        start_s, last_s, take_s, active_s, qual_s;
  logic [10:0] lo_x_s;
  logic [10:0] bmin_x_s, bmax_x_s, nmin_x_s, nmax_x_s;
  logic [9:0]  bmin_y_s, bmax_y_s, nmin_y_s, nmax_y_s;
  logic [20:0] bcnt_s, ncnt_s;

`ifdef BBOX_MASK_DEBOUNCE_EN
  logic [10:0] prev_h_r;
  logic [9:0]  prev_v_r;
  logic        prev_mask_r;
`endif

  // Register the raw pixel stream once before any decisions are made.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      h1_r     <= 11'd0;
      v1_r     <= 10'd0;
      valid1_r <= 1'b0;
      mask1_r  <= 1'b0;
    end else begin
      h1_r     <= hcount_in;
      v1_r     <= vcount_in;
      valid1_r <= valid_in;
      mask1_r  <= mask_in;
    end
  end

`ifdef BBOX_MASK_DEBOUNCE_EN
  // Remember the previous valid pixel so a masked pixel can be paired with its left neighbour.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      prev_h_r    <= 11'd0;
      prev_v_r    <= 10'd0;
      prev_mask_r <= 1'b0;
    end else if (valid1_r) begin
      prev_h_r    <= h1_r;
      prev_v_r    <= v1_r;
      prev_mask_r <= mask1_r && (h1_r < H_ACT_C) && (v1_r < V_ACT_C);
    end
  end
`endif

  // Decide whether the stage-1 pixel is taken and compute the updated extents.
  always_comb begin
    start_s  = valid1_r && (h1_r == 11'd0) && (v1_r == 10'd0);
    last_s   = valid1_r && (h1_r == H_LAST_C) && (v1_r == V_LAST_C);
    take_s   = valid1_r && (start_s || (state_r == ST_ACCUM));
    active_s = (h1_r < H_ACT_C) && (v1_r < V_ACT_C);
`ifdef BBOX_MASK_DEBOUNCE_EN
    qual_s   = valid1_r && active_s && mask1_r && prev_mask_r && (h1_r != 11'd0) &&
               (prev_h_r == (h1_r - 11'd1)) && (prev_v_r == v1_r);
    lo_x_s   = h1_r - 11'd1;
`else
    qual_s   = valid1_r && active_s && mask1_r;
    lo_x_s   = h1_r;
`endif
    // a frame start (or resync) discards whatever was accumulated before
    if (start_s) begin
      bmin_x_s = 11'h7FF;
      bmin_y_s = 10'h3FF;
      bmax_x_s = 11'd0;
      bmax_y_s = 10'd0;
      bcnt_s   = 21'd0;
    end else begin
      bmin_x_s = min_x_r;
      bmin_y_s = min_y_r;
      bmax_x_s = max_x_r;
      bmax_y_s = max_y_r;
      bcnt_s   = cnt_r;
    end
    if (qual_s) begin
      nmin_x_s = (lo_x_s < bmin_x_s) ? lo_x_s : bmin_x_s;
      nmax_x_s = (h1_r > bmax_x_s) ? h1_r : bmax_x_s;
      nmin_y_s = (v1_r < bmin_y_s) ? v1_r : bmin_y_s;
      nmax_y_s = (v1_r > bmax_y_s) ? v1_r : bmax_y_s;
      ncnt_s   = (bcnt_s == CNT_MAX_C) ? bcnt_s : (bcnt_s + 21'd1);
    end else begin
      nmin_x_s = bmin_x_s;
      nmax_x_s = bmax_x_s;
      nmin_y_s = bmin_y_s;
      nmax_y_s = bmax_y_s;
      ncnt_s   = bcnt_s;
    end
  end

  // Frame FSM and accumulators; the last pixel hands the totals to the output stage.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_r <= ST_IDLE;
      min_x_r <= 11'h7FF;
      min_y_r <= 10'h3FF;
      max_x_r <= 11'd0;
      max_y_r <= 10'd0;
      cnt_r   <= 21'd0;
      done_r  <= 1'b0;
    end else begin
      done_r <= take_s && last_s;
      if (take_s) begin
        min_x_r <= nmin_x_s;
        min_y_r <= nmin_y_s;
        max_x_r <= nmax_x_s;
        max_y_r <= nmax_y_s;
        cnt_r   <= ncnt_s;
        state_r <= last_s ? ST_IDLE : ST_ACCUM;
      end
    end
  end

  // Publish results and run the valid/ready handshake; overrun is sticky until reset.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      rect_valid_out  <= 1'b0;
      found_out       <= 1'b0;
      x_out_1         <= 11'd0;
      y_out_1         <= 10'd0;
      x_out_2         <= 11'd0;
      y_out_2         <= 10'd0;
      pixel_count_out <= 21'd0;
      overrun_out     <= 1'b0;
    end else if (done_r) begin
      rect_valid_out  <= 1'b1;
      found_out       <= (cnt_r != 21'd0) && (cnt_r >= MIN_C);
      pixel_count_out <= cnt_r;
      if (cnt_r == 21'd0) begin
        x_out_1 <= 11'd0;
        y_out_1 <= 10'd0;
        x_out_2 <= 11'd0;
        y_out_2 <= 10'd0;
      end else begin
        x_out_1 <= min_x_r;
        y_out_1 <= min_y_r;
        x_out_2 <= max_x_r + 11'd1;
        y_out_2 <= max_y_r + 10'd1;
      end
      if (rect_valid_out && !rect_ready_in) begin
        overrun_out <= 1'b1;
      end
    end else if (rect_valid_out && rect_ready_in) begin
      rect_valid_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bbox_extractor.sv
// Scoreboard bench for bbox_extractor: stimulus pushes hand-computed results,
// a negedge monitor pops and compares on every handshake transfer.
module tb_bbox_extractor;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic [10:0] hcount_in;
  logic [9:0]  vcount_in;
  logic        valid_in;
  logic        mask_in;
  logic        rect_ready_in;
  logic        rect_valid_out;
  logic        found_out;
  logic [10:0] x_out_1;
  logic [9:0]  y_out_1;
  logic [10:0] x_out_2;
  logic [9:0]  y_out_2;
  logic [20:0] pixel_count_out;
  logic        overrun_out;

  typedef struct packed {
    logic        found;
    logic [10:0] x1;
    logic [9:0]  y1;
    logic [10:0] x2;
    logic [9:0]  y2;
    logic [20:0] cnt;
  } res_t;

  res_t exp_q[$];
  res_t got;
  int   tests = 0;
  int   fails = 0;

  bbox_extractor dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .valid_in(valid_in), .mask_in(mask_in),
    .rect_ready_in(rect_ready_in), .rect_valid_out(rect_valid_out),
    .found_out(found_out), .x_out_1(x_out_1), .y_out_1(y_out_1),
    .x_out_2(x_out_2), .y_out_2(y_out_2),
    .pixel_count_out(pixel_count_out), .overrun_out(overrun_out)
  );

  always #5 clk_in = ~clk_in;

  assign got = {found_out, x_out_1, y_out_1, x_out_2, y_out_2, pixel_count_out};

  // monitor: a transfer happens on the next rising edge, so check it here
  always @(negedge clk_in) begin
    if (rst_n_in && rect_valid_out && rect_ready_in) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_result: got f=%0d (%0d,%0d)-(%0d,%0d) n=%0d, required none",
                 got.found, got.x1, got.y1, got.x2, got.y2, got.cnt);
      end else begin
        res_t e;
        e = exp_q.pop_front();
        if (got !== e) begin
          fails++;
          $display("FAIL result: got f=%0d (%0d,%0d)-(%0d,%0d) n=%0d, required f=%0d (%0d,%0d)-(%0d,%0d) n=%0d",
                   got.found, got.x1, got.y1, got.x2, got.y2, got.cnt,
                   e.found, e.x1, e.y1, e.x2, e.y2, e.cnt);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic push(input int f, input int x1, input int y1, input int x2, input int y2, input int n);
    res_t r;
    r.found = 1'(f);
    r.x1 = 11'(x1);
    r.y1 = 10'(y1);
    r.x2 = 11'(x2);
    r.y2 = 10'(y2);
    r.cnt = 21'(n);
    exp_q.push_back(r);
  endtask

  // idle values are deliberately (0,0) masked so a non-valid cycle must be ignored
  task automatic drop();
    valid_in  = 1'b0;
    hcount_in = 11'd0;
    vcount_in = 10'd0;
    mask_in   = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_in);
      drop();
    end
  endtask

  task automatic send(input int h, input int v, input logic m);
    @(negedge clk_in);
    hcount_in = 11'(h);
    vcount_in = 10'(v);
    mask_in   = m;
    valid_in  = 1'b1;
  endtask

  task automatic rect_body(input int x1, input int y1, input int x2, input int y2, input bit gaps);
    for (int y = y1; y < y2; y++) begin
      for (int x = x1; x < x2; x++) begin
        if (!(x == 0 && y == 0) && !(x == 1279 && y == 719)) begin
          send(x, y, 1'b1);
          if (gaps && ((x + y) % 5 == 0)) idle(1);
        end
      end
    end
  endtask

  task automatic rect_frame(input int x1, input int y1, input int x2, input int y2, input bit gaps);
    send(0, 0, (x1 == 0 && y1 == 0));
    rect_body(x1, y1, x2, y2, gaps);
    send(1279, 719, (x2 == 1280 && y2 == 720));
    idle(2);
  endtask

  initial begin
    rst_n_in      = 1'b0;
    rect_ready_in = 1'b1;
    drop();
    repeat (3) @(posedge clk_in);
    #1;
    check("reset_valid", 32'(rect_valid_out), 32'd0);
    check("reset_x2", 32'(x_out_2), 32'd0);
    check("reset_count", 32'(pixel_count_out), 32'd0);
    check("reset_overrun", 32'(overrun_out), 32'd0);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    idle(2);

    // 128x128 square with raster gaps
    push(1, 100, 50, 228, 178, 16384);
    rect_frame(100, 50, 228, 178, 1'b1);
    idle(4);

    // empty frame
    push(0, 0, 0, 0, 0, 0);
    send(0, 0, 1'b0);
    send(1279, 719, 1'b0);
    idle(4);

    // one pixel below the found threshold, then exactly at it
    push(0, 20, 5, 35, 6, 15);
    rect_frame(20, 5, 35, 6, 1'b0);
    idle(4);
    push(1, 600, 400, 604, 404, 16);
    rect_frame(600, 400, 604, 404, 1'b1);
    idle(4);

    // single pixel at the last position: latency of two edges
    push(0, 1279, 719, 1280, 720, 1);
    send(0, 0, 1'b0);
    send(1279, 719, 1'b1);
    @(posedge clk_in);
    #1 drop();
    @(posedge clk_in);
    #1 check("latency_n1_valid", 32'(rect_valid_out), 32'd0);
    @(posedge clk_in);
    #1 check("latency_n2_valid", 32'(rect_valid_out), 32'd1);
    idle(4);

    // rectangle touching the origin
    push(0, 0, 0, 3, 2, 6);
    rect_frame(0, 0, 3, 2, 1'b0);
    idle(4);

    // out-of-active masked pixels are ignored
    push(0, 10, 20, 13, 24, 12);
    send(0, 0, 1'b0);
    send(1300, 20, 1'b1);
    rect_body(10, 20, 13, 24, 1'b0);
    send(1000, 600, 1'b0);
    send(5, 730, 1'b1);
    send(2047, 1023, 1'b1);
    send(1279, 719, 1'b0);
    idle(4);

    // new result on the same edge as a transfer: no overrun
    @(posedge clk_in);
    #1 rect_ready_in = 1'b0;
    push(0, 30, 40, 32, 41, 2);
    rect_frame(30, 40, 32, 41, 1'b0);
    idle(3);
    check("pending_p_valid", 32'(rect_valid_out), 32'd1);
    check("pending_p_x1", 32'(x_out_1), 32'd30);
    push(0, 70, 80, 71, 81, 1);
    send(0, 0, 1'b0);
    send(70, 80, 1'b1);
    send(1279, 719, 1'b0);
    @(posedge clk_in);
    #1 drop();
    @(posedge clk_in);
    #1 rect_ready_in = 1'b1;
    repeat (3) @(posedge clk_in);
    #1;
    check("same_edge_valid_drop", 32'(rect_valid_out), 32'd0);
    check("same_edge_overrun", 32'(overrun_out), 32'd0);

    // overrun: A replaced by B while ready is low
    rect_ready_in = 1'b0;
    rect_frame(200, 100, 210, 110, 1'b0);
    idle(4);
    check("hold_a_valid", 32'(rect_valid_out), 32'd1);
    check("hold_a_x1", 32'(x_out_1), 32'd200);
    check("hold_a_count", 32'(pixel_count_out), 32'd100);
    check("hold_a_overrun", 32'(overrun_out), 32'd0);
    push(0, 300, 200, 302, 203, 6);
    rect_frame(300, 200, 302, 203, 1'b0);
    idle(4);
    check("hold_b_x1", 32'(x_out_1), 32'd300);
    check("hold_b_y2", 32'(y_out_2), 32'd203);
    check("hold_b_overrun", 32'(overrun_out), 32'd1);
    check("hold_b_valid", 32'(rect_valid_out), 32'd1);
    @(posedge clk_in);
    #1 rect_ready_in = 1'b1;
    @(posedge clk_in);
    #1 rect_ready_in = 1'b0;
    check("one_cycle_ready_drop", 32'(rect_valid_out), 32'd0);
    check("overrun_sticky", 32'(overrun_out), 32'd1);
    @(posedge clk_in);
    #1 rect_ready_in = 1'b1;

    // reset mid-frame at (640,360)
    send(0, 0, 1'b0);
    rect_body(630, 360, 641, 361, 1'b0);
    @(posedge clk_in);
    #2 rst_n_in = 1'b0;
    #1;
    check("midreset_x1", 32'(x_out_1), 32'd0);
    check("midreset_count", 32'(pixel_count_out), 32'd0);
    check("midreset_overrun", 32'(overrun_out), 32'd0);
    check("midreset_valid", 32'(rect_valid_out), 32'd0);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    rect_body(641, 360, 650, 361, 1'b0);
    send(1279, 719, 1'b1);
    idle(4);

    // resync: (0,0) mid-frame discards the partial rectangle
    push(0, 700, 500, 702, 502, 4);
    send(0, 0, 1'b0);
    rect_body(50, 50, 53, 53, 1'b0);
    send(0, 0, 1'b0);
    rect_body(700, 500, 702, 502, 1'b1);
    send(1279, 719, 1'b0);
    idle(4);

    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk_in);
    #1 check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    idle(4);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bbox_extractor.md
Name: bbox_extractor

Overview:
- Inverse of the rectangle renderer: consumes a per-pixel object mask in raster order and recovers the axis-aligned bounding rectangle of all masked pixels in each frame.
- Sits after the colour-threshold/mask stage of the camera pipeline.
- Publishes one corner pair per frame on a valid/ready handshake to the physics and drawing logic.
- Coordinate convention matches the renderer: half-open interval [x_1, x_2) × [y_1, y_2). A mask rendered from corners (a, b) therefore returns exactly (a, b).

Parameters:
H_ACTIVE, 1280, active pixels per line; pixels with hcount_in >= H_ACTIVE are ignored
V_ACTIVE, 720, active lines per frame; pixels with vcount_in >= V_ACTIVE are ignored
MIN_PIXELS, 16, minimum qualifying pixel count for found_out=1

Ports:
clk_in  input  1  system clock, all logic on rising edge
rst_n_in  input  1  reset, asynchronous assert, active-low
hcount_in  input  11  pixel column
vcount_in  input  10  pixel row
valid_in  input  1  pixel qualifier; inputs are ignored when low
mask_in  input  1  pixel belongs to the object
rect_ready_in  input  1  consumer accepts the result
rect_valid_out  output  1  result pending
found_out  output  1  pixel_count_out >= MIN_PIXELS
x_out_1  output  11  min masked x
y_out_1  output  10  min masked y
x_out_2  output  11  max masked x + 1 (exclusive)
y_out_2  output  10  max masked y + 1 (exclusive)
pixel_count_out  output  21  qualifying pixels in the frame, saturating
overrun_out  output  1  sticky: a pending result was overwritten

Behaviour:
- Reset (async, rst_n_in=0): every output is 0. Accumulators are cleared and the FSM enters IDLE.
- Input stage: hcount_in, vcount_in, valid_in and mask_in are registered once (stage 1). Accumulation happens in stage 2.
- FSM IDLE: wait for a registered valid pixel at (0,0). On that pixel, clear the accumulators, process the pixel, and go to ACCUM.
- FSM ACCUM: for each registered valid in-active-region pixel with mask=1, min_x/min_y/max_x/max_y update and count increments (saturating at 2^21-1).
  - A valid pixel at (0,0) while in ACCUM is a resync: discard the partial frame and restart accumulation with that pixel. No result is published.
  - The valid pixel at (H_ACTIVE-1, V_ACTIVE-1) ends the frame. The result, including that pixel, is loaded into the output registers and the FSM returns to IDLE.
- Latency: if the last pixel is presented at input edge N, rect_valid_out=1 and outputs are stable after edge N+2.
- Result encoding:
  - found_out = (count >= MIN_PIXELS); x_out_2 = max_x+1 and y_out_2 = max_y+1 (max values 1280/720 fit in the widths).
  - If count = 0, the coordinates are 0 and found_out = 0.
  - If 0 < count < MIN_PIXELS, the coordinates are still reported and found_out = 0.
- Handshake: a transfer occurs on an edge with rect_valid_out & rect_ready_in. All result outputs hold while rect_valid_out & !rect_ready_in.
  - Transfer with no new result: rect_valid_out drops next cycle.
  - New result while pending and no transfer: the old result is replaced, rect_valid_out stays 1, overrun_out sets (cleared only by reset).
  - New result on the same edge as a transfer: the new result loads, rect_valid_out stays 1, no overrun.
- Non-valid cycles (valid_in=0) mid-frame: state holds. Gaps in the raster are tolerated.
- Reset mid-frame: the partial frame is lost. Accumulation resumes at the next (0,0).

Optional Feature:
BBOX_MASK_DEBOUNCE_EN
- Defined: a masked pixel qualifies only if the previous valid pixel on the same row (hcount-1) was also masked. Both pixels are then included in min/max, and the count increments by 1 per qualifying pixel. hcount=0 never qualifies on its own. Isolated single-pixel noise is rejected.
- Undefined: every masked pixel qualifies (behaviour above).

Test Plan:
- Mask = 1 for x 100..227, y 50..177 over a full 1280x720 frame -> one pulse with x_out_1=100, y_out_1=50, x_out_2=228, y_out_2=178, pixel_count_out=16384, found_out=1.
- All-zero frame -> rect_valid_out=1, found_out=0, all coordinates 0, pixel_count_out=0.
- MIN_PIXELS=1, single masked pixel at (1279,719) -> (1279,719),(1280,720), count 1, found 1, valid asserted 2 edges after the last pixel.
- rect_ready_in=0 across two frames (rect A then rect B) -> outputs show A until frame 2 ends, then B. overrun_out=1. Raising ready for one cycle drops valid.
- rst_n_in pulsed low mid-frame at (640,360) -> all outputs 0 immediately. A partial frame followed by a full frame yields only the full frame's result. A (0,0) resync mid-ACCUM discards the partial data.
- BBOX_MASK_DEBOUNCE_EN defined: isolated pixels at (10,10) plus a 2-wide run at x 500..501, y 300 -> x 500..502, y 300..301, count 1 (found_out per MIN_PIXELS=1).
